// File: rtl/spi_pkg.sv
// Shared definitions for the SPI host: FSM states, spi_mode field positions
// and the idle chip-select pattern.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        TRAIL,
        DONE
    } spi_state_t;

    localparam int CPOL_IDX = 0;
    localparam int CPHA_IDX = 1;

    // Wide enough for any chip-select count; users slice the low bits.
    localparam logic [31:0] CS_IDLE = '1;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: one tick every div+1 enabled cycles while running, plus
// leading/trailing edge strobes and the serial clock during XFER.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             clk_en,
    input  logic             run,
    input  logic             xfer,
    input  logic             cpol,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead,
    output logic             trail,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic             phase_reg, phase_next;

    assign tick  = clk_en && run && (cnt_reg == div);
    assign lead  = tick && xfer && !phase_reg;
    assign trail = tick && xfer && phase_reg;
    // Masking with xfer returns sclk to idle level the moment XFER is left.
    assign sclk  = cpol ^ (xfer && phase_reg);

    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        if (!run || (cnt_reg == div)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
        if (!xfer) begin
            phase_next = 1'b0;
        end else if (cnt_reg == div) begin
            phase_next = !phase_reg;
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (clk_en) begin
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/spi_host.sv
// SPI host controller: 1..DATA_WIDTH/8 byte MSB-first transfers in all four
// modes, programmable SCLK divider, one-cold chip selects and abort.
module spi_host
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PERI_CNT   = 4,
    parameter int DIV_W      = 8
) (
    input  logic                            clk,
    input  logic                            sync_rst_n,
    input  logic                            clk_en,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [1:0]                      spi_mode,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] byte_sel,
    input  logic [DIV_W-1:0]                clk_div,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    input  logic [$clog2(PERI_CNT)-1:0]     cs_sel,
    input  logic                            abort,
    input  logic                            poci,
    output logic                            sclk,
    output logic                            copi,
    output logic [PERI_CNT-1:0]             cs_n,
    output logic                            busy,
    output logic [$clog2(DATA_WIDTH):0]     bit_count,
    output logic                            done,
    output logic [DATA_WIDTH-1:0]           rx_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int CSW   = $clog2(PERI_CNT);

    spi_state_t            state_reg, state_next;
    logic [1:0]            mode_reg;
    logic [DIV_W-1:0]      div_reg;
    logic [CSW-1:0]        cs_sel_reg;
    logic [DATA_WIDTH:0]   tx_sh_reg;
    logic [DATA_WIDTH-1:0] rx_sh_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic [CNT_W-1:0]      bit_count_reg;

    logic                  accept, active, cpha;
    logic                  tick, lead, trail, sample_en, shift_en, last_edge;
    logic [CNT_W-1:0]      nbits;
    logic [DATA_WIDTH-1:0] tx_aligned;
    logic [PERI_CNT-1:0]   cs_hit;

    assign accept     = clk_en && start_valid && (state_reg == IDLE);
    assign active     = (state_reg == SETUP) || (state_reg == XFER) || (state_reg == TRAIL);
    assign cpha       = mode_reg[CPHA_IDX];
    assign nbits      = CNT_W'({byte_sel, 3'b000}) + CNT_W'(8);
    // Left-justify so bit 8n-1 sits at the top; bits above it fall off.
    assign tx_aligned = tx_data << (CNT_W'(DATA_WIDTH) - nbits);
    assign sample_en  = cpha ? trail : lead;
    assign shift_en   = cpha ? lead : trail;
    // The final SCLK edge is always a trailing one; in CPHA=1 it is also the last sample.
    assign last_edge  = trail && (bit_count_reg == (cpha ? CNT_W'(1) : CNT_W'(0)));

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clk_en     (clk_en),
        .run        (active),
        .xfer       (state_reg == XFER),
        .cpol       (mode_reg[CPOL_IDX]),
        .div        (div_reg),
        .tick       (tick),
        .lead       (lead),
        .trail      (trail),
        .sclk       (sclk)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_valid) state_next = SETUP;
            SETUP:   if (abort) state_next = IDLE; else if (tick) state_next = XFER;
            XFER:    if (abort) state_next = IDLE; else if (last_edge) state_next = TRAIL;
            TRAIL:   if (abort) state_next = IDLE; else if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_reg     <= IDLE;
            mode_reg      <= '0;
            div_reg       <= '0;
            cs_sel_reg    <= '0;
            tx_sh_reg     <= '0;
            rx_sh_reg     <= '0;
            rx_data_reg   <= '0;
            bit_count_reg <= '0;
        end else if (clk_en) begin
            state_reg <= state_next;
            if (accept) begin
                mode_reg      <= spi_mode;
                div_reg       <= clk_div;
                cs_sel_reg    <= cs_sel;
                // CPHA=1 parks a pad bit on top so the first leading-edge shift presents the MSB.
                tx_sh_reg     <= spi_mode[CPHA_IDX] ? {1'b0, tx_aligned} : {tx_aligned, 1'b0};
                rx_sh_reg     <= '0;
                bit_count_reg <= nbits;
            end else begin
                if (shift_en) begin
                    tx_sh_reg <= {tx_sh_reg[DATA_WIDTH-1:0], 1'b0};
                end
                if (sample_en) begin
                    rx_sh_reg     <= {rx_sh_reg[DATA_WIDTH-2:0], poci};
                    bit_count_reg <= bit_count_reg - 1'b1;
                end
            end
            if ((state_reg == TRAIL) && (state_next == DONE)) begin
                rx_data_reg <= rx_sh_reg;
            end
        end
    end

    for (genvar gi = 0; gi < PERI_CNT; gi++) begin : g_cs
        assign cs_hit[gi] = (cs_sel_reg == CSW'(gi));
    end

    assign cs_n        = active ? (CS_IDLE[PERI_CNT-1:0] & ~cs_hit) : CS_IDLE[PERI_CNT-1:0];
    assign copi        = active && tx_sh_reg[DATA_WIDTH];
    assign busy        = (state_reg != IDLE);
    assign start_ready = (state_reg == IDLE);
    assign done        = clk_en && (state_reg == DONE);
    assign bit_count   = bit_count_reg;
    assign rx_data     = rx_data_reg;

endmodule

// File: doc/spi_host.md
SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, shift register width in bits; a multiple of 8, at least 8.
REQ-002 SHALL have parameter PERI_CNT, 4, number of chip selects.
REQ-003 SHALL have parameter DIV_W, 8, clock-divider field width.
REQ-004 SHALL have port clk  input  1  system clock; reset sync_rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have port sync_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clk_en  input  1  global advance enable; all state holds when low.
REQ-007 SHALL have port start_valid  input  1  transaction request.
REQ-008 SHALL have port start_ready  output  1  request acceptable.
REQ-009 SHALL have port spi_mode  input  2  [0]=CPOL, [1]=CPHA.
REQ-010 SHALL have port byte_sel  input  $clog2(DATA_WIDTH/8)  transfer length n = byte_sel+1 bytes.
REQ-011 SHALL have port clk_div  input  DIV_W  SCLK half-period = clk_div+1 enabled cycles.
REQ-012 SHALL have port tx_data  input  DATA_WIDTH  transmit word.
REQ-013 SHALL have port cs_sel  input  $clog2(PERI_CNT)  target peripheral index.
REQ-014 SHALL have port abort  input  1  cancel the active transaction.
REQ-015 SHALL have port poci  input  1  serial data in.
REQ-016 SHALL have port sclk  output  1  serial clock.
REQ-017 SHALL have port copi  output  1  serial data out.
REQ-018 SHALL have port cs_n  output  PERI_CNT  one-cold chip selects.
REQ-019 SHALL have port busy  output  1  transaction active.
REQ-020 SHALL have port bit_count  output  $clog2(DATA_WIDTH)+1  bits remaining.
REQ-021 SHALL have port done  output  1  one-cycle completion pulse.
REQ-022 SHALL have port rx_data  output  DATA_WIDTH  received word.

Function
REQ-023 SHALL implement FSM states IDLE->SETUP->XFER->TRAIL->DONE->IDLE; only enabled cycles (clk_en=1) count.
REQ-024 SHALL assert start_ready only in IDLE; accept occurs when start_valid&&start_ready&&clk_en, latching spi_mode, byte_sel, clk_div, cs_sel and tx_data.
REQ-025 SHALL drive cs_n[cs_sel] low from the cycle after accept until leaving TRAIL; all other cs_n bits stay high; cs_sel>=PERI_CNT leaves all cs_n high but the transaction still runs.
REQ-026 SHALL hold sclk at CPOL in IDLE, SETUP, TRAIL and DONE; SETUP and TRAIL each last clk_div+1 cycles.
REQ-027 SHALL generate 8n SCLK periods in XFER, toggling every clk_div+1 cycles.
REQ-028 SHALL shift MSB first from tx_data[8n-1] down to tx_data[0]; tx bits above 8n-1 are ignored.
REQ-029 CPHA=0: SHALL present the first bit on copi at SETUP entry, sample poci on the leading edge, and shift on the trailing edge.
REQ-030 CPHA=1: SHALL shift on the leading edge and sample on the trailing edge.
REQ-031 SHALL assemble received bits into rx_data[8n-1:0] with the upper bits zero, update rx_data on entry to DONE, and hold it until the next DONE.
REQ-032 SHALL load bit_count with 8n at accept and decrement it on each sample edge, reaching 0 at XFER exit.
REQ-033 SHALL pulse done for exactly one cycle in DONE, at accept cycle + (16n+2)(clk_div+1) + 1.
REQ-034 SHALL assert busy in every state except IDLE.
REQ-035 abort in SETUP/XFER/TRAIL SHALL return to IDLE next enabled cycle with cs_n all high, sclk=CPOL, no done, and rx_data unchanged; abort in IDLE or DONE SHALL be ignored.
REQ-036 start_valid during busy SHALL be ignored, with no queuing.
REQ-037 SHALL hold copi low outside SETUP/XFER/TRAIL.

Reset
REQ-038 On sync_rst_n low, SHALL asynchronously enter IDLE with sclk=0, copi=0, cs_n all 1, busy=0, done=0, bit_count=0, rx_data=0, start_ready=1 (after release).
REQ-039 Reset mid-transaction SHALL abandon it with no done pulse.

Structure
REQ-040 Package spi_pkg SHALL hold the state enum, the spi_mode field indices and the CS_IDLE constant.
REQ-041 Sub-module spi_clk_gen SHALL hold the divider and emit lead/trail edge strobes and sclk.

Verification
REQ-042 Mode 0, n=1, clk_div=0, tx=0xA5, poci looped to copi -> rx_data=0xA5, done at accept+19.
REQ-043 Mode 3, n=8, clk_div=3, tx=0x0123456789ABCDEF, poci looped back -> rx identical, done at accept+521, cs_n=4'b1110 for cs_sel=0.
REQ-044 Mode 1, n=2, poci tied 1 -> rx_data=0x000000000000FFFF.
REQ-045 abort asserted mid-XFER (bit_count=5) -> IDLE next cycle, cs_n=4'b1111, no done, rx_data unchanged.
REQ-046 Reset asserted in XFER, and clk_en toggled 50% during a transfer -> reset values immediately on reset; with clk_en toggling, timing stretches exactly with enabled cycles.
